// File: rtl/disp_source_arbiter.sv
// disp_source_arbiter
//   Shares one 4-digit hex display between three 16-bit sources. Requesting
//   sources are shown in round-robin order, each for a fixed dwell of
//   HOLD_MS ticks (one tick = Fclk/F1kHz clock cycles). A manual override
//   pins one source, or blanks the display when sel = 3.
//
// Request semantics: src_req is a level, not a handshake. A source is
//   eligible for as long as its bit is high, and dropping the bit
//   withdraws it on the next edge. There is no acknowledge back to the sources.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   src_req    per-source request, bit i = source i has data to show
//   src0_dat   source 0 word
//   src1_dat   source 1 word
//   src2_dat   source 2 word
//   sel_en     manual override enable (highest priority)
//   sel        manual source index (0..2, 3 = blank)
//   dat        word to display driver
//   cur_src    index of source currently shown
//   disp_on    1 = dat is valid and should be lit
//   switch_p   one-cycle pulse on every change of cur_src
//   state_dbg  current FSM state (0 IDLE, 1 SHOW, 2 MANUAL)
module disp_source_arbiter #(
  parameter int Fclk    = 50000,
  parameter int F1kHz   = 1,
  parameter int HOLD_MS = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  src_req,
  input  logic [15:0] src0_dat,
  input  logic [15:0] src1_dat,
  input  logic [15:0] src2_dat,
  input  logic        sel_en,
  input  logic [1:0]  sel,
  output logic [15:0] dat,
  output logic [1:0]  cur_src,
  output logic        disp_on,
  output logic        switch_p,
  output logic [1:0]  state_dbg
);

  localparam int TICK_DIV = Fclk / F1kHz;
  localparam int CW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW       = (HOLD_MS > 1) ? $clog2(HOLD_MS) : 1;
  localparam logic [CW-1:0] TICK_MAX  = CW'(TICK_DIV - 1);
  localparam logic [DW-1:0] HOLD_LAST = DW'(HOLD_MS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHOW   = 2'd1,
    MANUAL = 2'd2
  } state_t;

  state_t        state, state_n;
  logic [1:0]    rr_ptr, rr_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [DW-1:0] dwell, dwell_n;
  logic [15:0]   dat_n;
  logic [1:0]    cur_n;
  logic          on_n, sw_n;

  logic          tick, expire;
  logic          grant;
  logic [1:0]    grant_idx;
  logic [1:0]    win_rr, win_cur;

  // First requesting index after ptr, wrapping through ptr itself last.
  // Falls back to ptr when nothing requests (callers check |req first).
  function automatic logic [1:0] rr_pick(input logic [1:0] ptr, input logic [2:0] req);
    logic [1:0] pick;
    logic [1:0] idx;
    pick = ptr;
    // Walk from the farthest candidate to the nearest so the nearest wins.
    for (int k = 3; k >= 1; k--) begin
      idx = 2'((int'(ptr) + k) % 3);
      if (req[idx]) pick = idx;
    end
    return pick;
  endfunction

  function automatic logic [15:0] src_word(input logic [1:0] idx, input logic [15:0] d0,
                                           input logic [15:0] d1, input logic [15:0] d2);
    case (idx)
      2'd0:    return d0;
      2'd1:    return d1;
      default: return d2;
    endcase
  endfunction

  assign tick      = (cnt == TICK_MAX);
  assign expire    = tick && (dwell == HOLD_LAST);
  assign win_rr    = rr_pick(rr_ptr, src_req);
  assign win_cur   = rr_pick(cur_src, src_req);
  assign state_dbg = state;

  always_comb begin
    state_n   = state;
    rr_n      = rr_ptr;
    cnt_n     = cnt;
    dwell_n   = dwell;
    dat_n     = dat;
    cur_n     = cur_src;
    on_n      = disp_on;
    sw_n      = 1'b0;
    grant     = 1'b0;
    grant_idx = cur_src;

    if (sel_en) begin
      // Override wins over dwell expiry and request drops.
      state_n = MANUAL;
      cnt_n   = '0;
      dwell_n = '0;
      if (sel != 2'd3) begin
        cur_n = sel;
        dat_n = src_word(sel, src0_dat, src1_dat, src2_dat);
        on_n  = 1'b1;
        sw_n  = (sel != cur_src);
      end else begin
        // Blank: dat and cur_src keep their last values.
        on_n = 1'b0;
      end
    end else begin
      case (state)
        IDLE: begin
          cnt_n   = '0;
          dwell_n = '0;
          on_n    = 1'b0;
          if (|src_req) begin
            grant     = 1'b1;
            grant_idx = win_rr;
          end
        end
        SHOW: begin
          if (!src_req[cur_src]) begin
            // A drop is handled before expiry so only one switch happens.
            if (|src_req) begin
              grant     = 1'b1;
              grant_idx = win_cur;
            end else begin
              state_n = IDLE;
              on_n    = 1'b0;
              cnt_n   = '0;
              dwell_n = '0;
            end
          end else if (expire) begin
            // Winner may be cur_src itself: that is a dwell restart, no pulse.
            grant     = 1'b1;
            grant_idx = win_cur;
          end else begin
            dat_n = src_word(cur_src, src0_dat, src1_dat, src2_dat);
            cnt_n = tick ? '0 : cnt + CW'(1);
            if (tick) dwell_n = dwell + DW'(1);
          end
        end
        MANUAL: begin
          // sel_en just fell: resume round robin after the pinned source.
          if (sel != 2'd3) rr_n = sel;
          state_n = IDLE;
          on_n    = 1'b0;
          cnt_n   = '0;
          dwell_n = '0;
        end
        default: begin
          state_n = IDLE;
          on_n    = 1'b0;
        end
      endcase

      if (grant) begin
        state_n = SHOW;
        cur_n   = grant_idx;
        rr_n    = grant_idx;
        dat_n   = src_word(grant_idx, src0_dat, src1_dat, src2_dat);
        on_n    = 1'b1;
        sw_n    = (grant_idx != cur_src);
        cnt_n   = '0;
        dwell_n = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rr_ptr   <= 2'd2;
      cnt      <= '0;
      dwell    <= '0;
      dat      <= 16'h0000;
      cur_src  <= 2'd0;
      disp_on  <= 1'b0;
      switch_p <= 1'b0;
    end else begin
      state    <= state_n;
      rr_ptr   <= rr_n;
      cnt      <= cnt_n;
      dwell    <= dwell_n;
      dat      <= dat_n;
      cur_src  <= cur_n;
      disp_on  <= on_n;
      switch_p <= sw_n;
    end
  end

endmodule
